sdram_cmd_packer: RTL
=====================

# sdram_cmd_packer

Avalon-MM slave front end that sits directly upstream of the SDRAM controller's 2-entry input FIFO. It accepts single and burst read/write requests and drives the FIFO write port. Each accepted beat becomes one 62-bit command word, which the FIFO holds for the SDRAM command sequencer. Read bursts are expanded into one FIFO entry per word. Write bursts are addressed from a captured base address.

## Interface
- ADDR_W, 25, word address width (32M × 32-bit words)
- BURST_W, 4, burstcount width; maximum burst is 2^BURST_W − 1 beats
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- avs_address  in  ADDR_W  word address (base address for bursts)
- avs_read  in  1  read request
- avs_write  in  1  write request / write-burst beat
- avs_writedata  in  32  write data
- avs_byteenable  in  4  active-high byte enables
- avs_burstcount  in  BURST_W  beats in burst; 0 is treated as 1
- avs_waitrequest  out  1  request not accepted this cycle
- fifo_wr  out  1  FIFO write strobe
- fifo_wr_data  out  62  packed command word
- fifo_full  in  1  FIFO full flag
- busy  out  1  burst in progress (state ≠ IDLE)

## Operation
- Command word layout:
  - [61] wr_n (1 = read, 0 = write)
  - [60:36] address
  - [35:32] be_n = ~byteenable
  - [31:0] data
  - For reads, data = 0 and be_n = ~avs_byteenable as presented at acceptance; this be_n is reused for every expanded read beat.
- accept = a beat is taken this cycle. fifo_wr = accept, combinational; fifo_wr_data is valid whenever fifo_wr = 1.
- fifo_wr is never asserted while fifo_full = 1 (the FIFO drops such writes silently).
- State machine: IDLE, RD_BURST, WR_BURST.
- IDLE:
  - avs_waitrequest = fifo_full.
  - Read has priority if avs_read and avs_write are both asserted.
  - On an accepted read: push {1, avs_address, ~be, 0}. If burstcount > 1: load remaining = burstcount − 1, next_addr = avs_address + 1, latch be_n, go to RD_BURST.
  - On an accepted write: push {0, avs_address, ~be, writedata}. If burstcount > 1: load remaining = burstcount − 1, next_addr = avs_address + 1, go to WR_BURST.
- RD_BURST:
  - avs_waitrequest = 1 regardless of inputs.
  - Each cycle with !fifo_full: push {1, next_addr, latched be_n, 0}, next_addr += 1, remaining −= 1.
  - When the pushed beat is the one with remaining = 1, go to IDLE on the following edge.
- WR_BURST:
  - avs_waitrequest = fifo_full | !avs_write.
  - avs_read is not accepted.
  - On avs_write && !fifo_full: push {0, next_addr, ~avs_byteenable, avs_writedata}, next_addr += 1, remaining −= 1.
  - After the last beat (remaining = 1 when pushed), go to IDLE.
- Address arithmetic is modulo 2^ADDR_W: a burst crossing the top wraps to 0 with no error.
- busy = 1 in RD_BURST and WR_BURST.

## Timing
- Latency 0: an accepted beat appears on fifo_wr/fifo_wr_data in the same cycle. The entry is at the FIFO output after the next clk edge.
- Read-burst expansion rate is one entry per cycle while the FIFO is not full. With a 2-deep FIFO and the consumer reading every cycle, throughput is 1 beat/cycle.
- Single-beat commands (burstcount 0 or 1) never leave IDLE. Back-to-back singles are accepted on consecutive cycles when fifo_full = 0.
- Reset, when reset_n = 0 at a clk edge:
  - Next state is IDLE; remaining = 0, next_addr = 0, latched be_n = 0.
  - While reset_n = 0, outputs are forced combinationally: avs_waitrequest = 1, fifo_wr = 0, busy = 0.
  - fifo_wr_data reads 0 in reset because it is muxed from zeroed registers/inputs gated by fifo_wr.
- Reset mid-burst abandons the remaining beats. Entries already pushed are the FIFO's responsibility (the FIFO is reset by the same reset_n).
- fifo_full rising mid-burst stalls the burst with no beat lost or duplicated. Expansion resumes on the first cycle fifo_full = 0.

## Test plan
- Single write: address 0x0000123, byteenable 0x3, writedata 0xDEADBEEF, burstcount 1, fifo_full = 0 → same-cycle fifo_wr = 1, fifo_wr_data = {0, 0x0000123, 0xC, 0xDEADBEEF}, waitrequest = 0, busy stays 0.
- Read burst of 4 at 0x1FFFFFE, byteenable 0xF, consumer always reading → 4 consecutive pushes with addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001, all wr_n = 1, be_n = 0. waitrequest = 1 for 3 cycles after acceptance; busy falls after the 4th push.
- Write burst of 3 with a 2-cycle gap in avs_write between beats 1 and 2 → waitrequest = 1 during the gap, no push during the gap. Beats land at base, base+1, base+2 with their own data/be_n.
- Backpressure: fifo_full held 1 for 5 cycles during a read burst of 6 → no fifo_wr while full, exactly 6 pushes total, addresses contiguous, no duplicates.
- Simultaneous avs_read and avs_write in IDLE → read accepted (wr_n = 1). Write stays pending with waitrequest = 1 until the read burst completes, then is accepted.
- reset_n = 0 during the 2nd beat of a read burst of 8 → the next cycle shows state IDLE, busy = 0, fifo_wr = 0. The first request after reset starts from its own address.

Source files
------------

// File: rtl/sdram_cmd_packer_if.sv
// sdram_cmd_packer_if: Avalon-MM slave request bus plus SDRAM input FIFO write port
interface sdram_cmd_packer_if #(
   parameter int ADDR_W  = 25,
   parameter int BURST_W = 4
);
   logic [ADDR_W-1:0]  avs_address;
   logic               avs_read;
   logic               avs_write;
   logic [31:0]        avs_writedata;
   logic [3:0]         avs_byteenable;
   logic [BURST_W-1:0] avs_burstcount;
   logic               avs_waitrequest;
   logic               fifo_wr;
   logic [ADDR_W+36:0] fifo_wr_data;
   logic               fifo_full;
   modport master (
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount, fifo_full,
      input  avs_waitrequest, fifo_wr, fifo_wr_data
   );
   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount, fifo_full,
      output avs_waitrequest, fifo_wr, fifo_wr_data
   );
endinterface

// File: rtl/sdram_cmd_packer.sv
// sdram_cmd_packer: packs Avalon-MM single/burst requests into one FIFO command word per beat
module sdram_cmd_packer #(
   parameter int ADDR_W  = 25,
   parameter int BURST_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   sdram_cmd_packer_if.slave bus,
   output logic              busy
);
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RD_BURST = 2'd1;
   localparam logic [1:0] S_WR_BURST = 2'd2;
   logic [1:0]         r_state;
   logic [BURST_W-1:0] r_remaining;
   logic [ADDR_W-1:0]  r_next_addr;
   logic [3:0]         r_be_n;
   logic               w_idle, w_rd, w_wr, w_rd_acc, w_wr_acc, w_rd_beat, w_push, w_wr_n, w_multi, w_last;
   logic [ADDR_W-1:0]  w_addr;
   logic [3:0]         w_be_n;
   logic [31:0]        w_data;

   // Decode which beat, if any, goes to the FIFO this cycle; reset and a full FIFO block every push
   always_comb begin
      w_idle    = r_state == S_IDLE;
      w_rd      = r_state == S_RD_BURST;
      w_wr      = r_state == S_WR_BURST;
      w_rd_acc  = reset_n && w_idle && bus.avs_read && !bus.fifo_full;
      w_wr_acc  = reset_n && ((w_idle && !bus.avs_read) || w_wr) && bus.avs_write && !bus.fifo_full;
      w_rd_beat = reset_n && w_rd && !bus.fifo_full;
      w_push    = w_rd_acc || w_wr_acc || w_rd_beat;
      w_wr_n    = w_rd_acc || w_rd_beat;
      w_multi   = bus.avs_burstcount > BURST_W'(1);
      w_last    = r_remaining == BURST_W'(1);
      w_addr    = w_idle ? bus.avs_address : r_next_addr;
      w_be_n    = w_rd_beat ? r_be_n : ~bus.avs_byteenable;
      w_data    = w_wr_n ? 32'd0 : bus.avs_writedata;
   end

   // Drive the FIFO write port and slave handshake; data is zero whenever no push happens
   always_comb begin
      bus.fifo_wr         = w_push;
      bus.fifo_wr_data    = w_push ? {w_wr_n, w_addr, w_be_n, w_data} : '0;
      bus.avs_waitrequest = !reset_n ? 1'b1 :
                            w_idle   ? bus.fifo_full :
                            w_wr     ? (bus.fifo_full || !bus.avs_write) : 1'b1;
      busy                = reset_n && !w_idle;
   end

   // Burst bookkeeping: load on a multi-beat accept in IDLE, count down on every burst beat pushed
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_next_addr <= '0;
         r_be_n      <= '0;
      end else if (w_idle) begin
         if ((w_rd_acc || w_wr_acc) && w_multi) begin
            r_state     <= w_rd_acc ? S_RD_BURST : S_WR_BURST;
            r_remaining <= bus.avs_burstcount - BURST_W'(1);
            r_next_addr <= bus.avs_address + ADDR_W'(1);
            if (w_rd_acc) r_be_n <= ~bus.avs_byteenable;
         end
      end else if (!w_rd && !w_wr) begin
         r_state <= S_IDLE;
      end else if (w_push) begin
         r_next_addr <= r_next_addr + ADDR_W'(1);
         r_remaining <= r_remaining - BURST_W'(1);
         if (w_last) r_state <= S_IDLE;
      end
   end
endmodule
